// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard control unit.
package hazard_pkg;
  localparam int REG_W      = 5;
  localparam int LOAD_CNT_W = 4;
  localparam int MDU_CNT_W  = 6;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_WAIT = 1'b1
  } ld_state_t;

  // $zero never carries a real dependency, so it can never match.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return (dst != ZERO_REG) && (dst == src);
  endfunction
endpackage

// File: rtl/stall_down_counter.sv
// Loadable down counter that saturates at zero; busy while non-zero.
module stall_down_counter
  import hazard_pkg::*;
#(
  parameter int W = LOAD_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         busy
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use, MDU-busy and redirect handling for the 5-stage core.
// Optional HAZARD_PERF_EN adds free-running stall/flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_CYCLES        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_HiLoRead,
  input  logic             ID_MduOp,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rt,
  input  logic             EX_MduStart,
  input  logic             EX_BranchTaken,
  output logic             PCWrite,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             mdu_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  localparam logic [LOAD_CNT_W-1:0] LOAD_RELOAD = LOAD_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [MDU_CNT_W-1:0]  MDU_RELOAD  = MDU_CNT_W'(MDU_CYCLES - 1);
  localparam bit                    LOAD_MULTI  = (LOAD_STALL_CYCLES > 1);

  ld_state_t               ld_state;
  logic [LOAD_CNT_W-1:0]   load_cnt;
  logic                    load_busy;
  logic [MDU_CNT_W-1:0]    mdu_cnt;
  logic                    mdu_cnt_busy;
  logic                    load_hit;
  logic                    ld_start;
  logic                    ld_wait;
  logic                    mdu_stall;
  logic                    stall;

  assign load_hit = EX_MemRead &&
                    (reg_match(EX_Rt, ID_Rs) || (ID_UsesRt && reg_match(EX_Rt, ID_Rt)));

  assign ld_wait   = (ld_state == LD_WAIT);
  // A taken branch squashes the stalled consumer, so no extra bubbles are owed.
  assign ld_start  = LOAD_MULTI && !ld_wait && load_hit && !EX_BranchTaken;
  assign mdu_stall = mdu_cnt_busy && (ID_HiLoRead || ID_MduOp);
  assign stall     = (load_hit && !ld_wait) || ld_wait || mdu_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state <= LD_IDLE;
    end else begin
      case (ld_state)
        LD_IDLE: if (ld_start) ld_state <= LD_WAIT;
        LD_WAIT: if (EX_BranchTaken || load_cnt <= LOAD_CNT_W'(1)) ld_state <= LD_IDLE;
        default: ld_state <= LD_IDLE;
      endcase
    end
  end

  stall_down_counter #(.W(LOAD_CNT_W)) u_load_cnt (
    .clk      (clk),
    .rst      (reset),
    .clear    (EX_BranchTaken),
    .load     (ld_start),
    .load_val (LOAD_RELOAD),
    .count    (load_cnt),
    .busy     (load_busy)
  );

  // The MDU op is already past EX, so redirects never clear this counter.
  stall_down_counter #(.W(MDU_CNT_W)) u_mdu_cnt (
    .clk      (clk),
    .rst      (reset),
    .clear    (1'b0),
    .load     (EX_MduStart),
    .load_val (MDU_RELOAD),
    .count    (mdu_cnt),
    .busy     (mdu_cnt_busy)
  );

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_stall = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    mdu_busy    = 1'b0;
    if (!reset) begin
      mdu_busy = mdu_cnt_busy;
      if (EX_BranchTaken) begin
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (stall) begin
        PCWrite     = 1'b0;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (ID_Jump) begin
        IF_ID_flush = 1'b1;
      end
    end
  end

  state_matches_counter: assert property (@(posedge clk) disable iff (reset)
    ld_wait == load_busy);

  // ID_MduOp stalls while busy, so a new start can only arrive once the count has drained.
  no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    EX_MduStart |-> (mdu_cnt == '0));

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall)       perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (IF_ID_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load bubbles) against vectors and a timeline model.
module tb_hazard_ctrl;
  localparam int MDU = 32;

  typedef struct {
    logic [4:0] rs, rt, ex_rt;
    logic uses_rt, hilo, mduop, jump, memrd, mdustart, br;
  } in_t;

  typedef struct {
    in_t        i;
    logic [4:0] e1, e3;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_Rt = '0;
  logic ID_UsesRt = 0, ID_HiLoRead = 0, ID_MduOp = 0, ID_Jump = 0;
  logic EX_MemRead = 0, EX_MduStart = 0, EX_BranchTaken = 0;
  logic pcw1, ifs1, iff1, idef1, busy1;
  logic pcw3, ifs3, iff3, idef3, busy3;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int ld_free[2];
  int mdu_t0;
  int lsc[2] = '{1, 3};
  vec_t tbl[$];

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MDU_CYCLES(MDU)) dut1 (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_HiLoRead(ID_HiLoRead), .ID_MduOp(ID_MduOp), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_MduStart(EX_MduStart),
    .EX_BranchTaken(EX_BranchTaken), .PCWrite(pcw1), .IF_ID_stall(ifs1),
    .IF_ID_flush(iff1), .ID_EX_flush(idef1), .mdu_busy(busy1));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MDU_CYCLES(MDU)) dut3 (
    .clk(clk), .reset(reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_HiLoRead(ID_HiLoRead), .ID_MduOp(ID_MduOp), .ID_Jump(ID_Jump),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_MduStart(EX_MduStart),
    .EX_BranchTaken(EX_BranchTaken), .PCWrite(pcw3), .IF_ID_stall(ifs3),
    .IF_ID_flush(iff3), .ID_EX_flush(idef3), .mdu_busy(busy3));

  always #5 clk = ~clk;

  function automatic in_t mk(int rs, int rt, bit uses, bit hilo, bit mduop, bit jump,
                             bit memrd, int ex_rt, bit start, bit br);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.ex_rt = 5'(ex_rt);
    v.uses_rt = uses; v.hilo = hilo; v.mduop = mduop; v.jump = jump;
    v.memrd = memrd; v.mdustart = start; v.br = br;
    return v;
  endfunction

  function automatic bit hit_of(in_t v);
    return v.memrd && v.ex_rt != 0 && (v.ex_rt == v.rs || (v.uses_rt && v.ex_rt == v.rt));
  endfunction

  function automatic bit mdu_busy_m();
    return (t > mdu_t0) && (t < mdu_t0 + MDU);
  endfunction

  // Output order: {PCWrite, IF_ID_stall, IF_ID_flush, ID_EX_flush, mdu_busy}
  function automatic logic [4:0] model_out(int k, in_t v);
    bit busy, stall;
    busy  = mdu_busy_m();
    stall = (t < ld_free[k]) || hit_of(v) || (busy && (v.hilo || v.mduop));
    if (v.br)        return {4'b1011, busy};
    else if (stall)  return {4'b0101, busy};
    else if (v.jump) return {4'b1010, busy};
    else             return {4'b1000, busy};
  endfunction

  task automatic model_reset();
    ld_free[0] = 0;
    ld_free[1] = 0;
    mdu_t0 = -1000;
  endtask

  task automatic model_update(in_t v);
    for (int k = 0; k < 2; k++) begin
      if (v.br) begin
        if (ld_free[k] > t + 1) ld_free[k] = t + 1;
      end else if (t >= ld_free[k] && hit_of(v)) begin
        ld_free[k] = t + lsc[k];
      end
    end
    if (v.mdustart) mdu_t0 = t;
  endtask

  task automatic chk(string nm, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %b expected %b", nm, t, act, exp);
    end
  endtask

  task automatic drive(in_t v);
    ID_Rs = v.rs; ID_Rt = v.rt; EX_Rt = v.ex_rt;
    ID_UsesRt = v.uses_rt; ID_HiLoRead = v.hilo; ID_MduOp = v.mduop;
    ID_Jump = v.jump; EX_MemRead = v.memrd; EX_MduStart = v.mdustart;
    EX_BranchTaken = v.br;
  endtask

  task automatic step(in_t v, bit use_exp, logic [4:0] e1, logic [4:0] e3, string nm);
    drive(v);
    #4;
    chk({nm, "/model_lsc1"}, {pcw1, ifs1, iff1, idef1, busy1}, model_out(0, v));
    chk({nm, "/model_lsc3"}, {pcw3, ifs3, iff3, idef3, busy3}, model_out(1, v));
    if (use_exp) begin
      chk({nm, "/lsc1"}, {pcw1, ifs1, iff1, idef1, busy1}, e1);
      chk({nm, "/lsc3"}, {pcw3, ifs3, iff3, idef3, busy3}, e3);
    end
    model_update(v);
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    in_t z, v;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed vectors starting from reset (rows are sequential).
    tbl.push_back('{z,                                   5'b10000, 5'b10000});
    tbl.push_back('{mk(8, 0, 0, 0, 0, 0, 1, 8, 0, 0),    5'b01010, 5'b01010});
    tbl.push_back('{z,                                   5'b10000, 5'b01010});
    tbl.push_back('{z,                                   5'b10000, 5'b01010});
    tbl.push_back('{z,                                   5'b10000, 5'b10000});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0),    5'b10000, 5'b10000});
    tbl.push_back('{mk(3, 9, 0, 0, 0, 0, 1, 9, 0, 0),    5'b10000, 5'b10000});
    tbl.push_back('{mk(3, 9, 1, 0, 0, 0, 1, 9, 0, 0),    5'b01010, 5'b01010});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1),    5'b10110, 5'b10110});
    tbl.push_back('{z,                                   5'b10000, 5'b10000});
    tbl.push_back('{mk(4, 0, 0, 0, 0, 1, 1, 4, 0, 0),    5'b01010, 5'b01010});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0),    5'b10100, 5'b01010});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0),    5'b10100, 5'b01010});
    tbl.push_back('{mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0),    5'b10100, 5'b10100});
    tbl.push_back('{mk(4, 0, 0, 0, 0, 0, 1, 4, 0, 1),    5'b10110, 5'b10110});
    tbl.push_back('{z,                                   5'b10000, 5'b10000});

    model_reset();
    drive(mk(8, 8, 1, 1, 1, 1, 1, 8, 0, 0));
    #2;
    chk("reset_forced_lsc1", {pcw1, ifs1, iff1, idef1, busy1}, 5'b10000);
    chk("reset_forced_lsc3", {pcw3, ifs3, iff3, idef3, busy3}, 5'b10000);
    drive(z);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;

    foreach (tbl[n]) step(tbl[n].i, 1'b1, tbl[n].e1, tbl[n].e3, $sformatf("vec%0d", n));

    // MDU: start pulse, then mfhi waits MDU-1 cycles; busy drops with the release.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1, 5'b10000, 5'b10000, "mdu_start");
    for (int i = 0; i < MDU - 1; i++)
      step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, 5'b01011, 5'b01011, "mdu_stall");
    step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b1, 5'b10000, 5'b10000, "mdu_release");

    // Reset while mdu_cnt is 20.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b0, 5'b0, 5'b0, "rst_mdu_start");
    for (int i = 0; i < 11; i++)
      step(z, 1'b1, 5'b10001, 5'b10001, "rst_mdu_busy");
    drive(mk(6, 0, 0, 1, 0, 0, 1, 6, 0, 0));
    reset = 1'b1;
    #1;
    chk("midrst_lsc1", {pcw1, ifs1, iff1, idef1, busy1}, 5'b10000);
    chk("midrst_lsc3", {pcw3, ifs3, iff3, idef3, busy3}, 5'b10000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t++;
    model_reset();
    step(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b1, 5'b10000, 5'b10000, "post_reset");

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 800; i++) begin
      v.rs = 5'($urandom_range(0, 3));
      v.rt = 5'($urandom_range(0, 3));
      v.ex_rt = 5'($urandom_range(0, 3));
      v.uses_rt = 1'($urandom_range(0, 1));
      v.memrd = ($urandom_range(0, 2) == 0);
      v.hilo = ($urandom_range(0, 3) == 0);
      v.mduop = ($urandom_range(0, 5) == 0);
      v.jump = ($urandom_range(0, 5) == 0);
      v.br = ($urandom_range(0, 9) == 0);
      v.mdustart = !mdu_busy_m() && ($urandom_range(0, 19) == 0);
      step(v, 1'b0, 5'b0, 5'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage MIPS core.
- Detects load-use hazards, multi-cycle MDU (mult/div) busy conflicts and control-flow redirects.
- Drives PCWrite plus the stall/flush inputs of the IF/ID register and the flush input of the ID/EX register.
- Owns the sequencing state for multi-cycle stalls: a load-wait counter and an MDU busy counter.

Parameters:
LOAD_STALL_CYCLES, 1, total bubble cycles inserted per load-use hazard (1..15; >1 for slow data memory)
MDU_CYCLES, 32, cycles from MDU start until HI/LO are valid (2..63)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ID_Rs  input  5  rs field of instruction in ID
ID_Rt  input  5  rt field of instruction in ID
ID_UsesRt  input  1  ID instruction reads rt as a source
ID_HiLoRead  input  1  ID instruction is mfhi/mflo
ID_MduOp  input  1  ID instruction is mult/multu/div/divu
ID_Jump  input  1  jump resolved in ID (j/jal/jr/jalr)
EX_MemRead  input  1  instruction in EX is a load
EX_Rt  input  5  destination register of the load in EX
EX_MduStart  input  1  MDU op entering execution this cycle (1-cycle pulse)
EX_BranchTaken  input  1  branch resolved taken in EX
PCWrite  output  1  PC update enable
IF_ID_stall  output  1  hold IF/ID contents
IF_ID_flush  output  1  zero IF/ID contents
ID_EX_flush  output  1  insert bubble into ID/EX
mdu_busy  output  1  MDU counter non-zero

Behaviour:
- Reset (async, takes effect immediately): load_cnt=0, mdu_cnt=0. While reset is high, outputs are forced to PCWrite=1, IF_ID_stall=0, IF_ID_flush=0, ID_EX_flush=0, mdu_busy=0.
- Outputs are combinational from current inputs plus registered counters. Zero-cycle response: stall is asserted in the same cycle the hazard appears.
- load_hit = EX_MemRead && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UsesRt && EX_Rt==ID_Rt)).
- Load FSM, states LD_IDLE (load_cnt==0) and LD_WAIT (load_cnt>0):
  - LD_IDLE with load_hit: stall this cycle. If LOAD_STALL_CYCLES>1, load_cnt<=LOAD_STALL_CYCLES-1.
  - LD_WAIT: stall, load_cnt decrements. Return to LD_IDLE when it reaches 0.
  - Total bubbles per hazard = LOAD_STALL_CYCLES exactly.
- MDU counter:
  - EX_MduStart loads mdu_cnt<=MDU_CYCLES-1. Otherwise it decrements while non-zero.
  - mdu_busy = (mdu_cnt!=0).
  - EX_MduStart while busy is a protocol violation; it is prevented because ID_MduOp stalls while busy.
- mdu_stall = mdu_busy && (ID_HiLoRead || ID_MduOp). The stall releases in the cycle mdu_cnt reaches 0.
- stall = load_hit (in LD_IDLE) || LD_WAIT || mdu_stall. When stall is active: PCWrite=0, IF_ID_stall=1, ID_EX_flush=1.
- Priority is EX_BranchTaken > stall > ID_Jump.
  - EX_BranchTaken: PCWrite=1, IF_ID_stall=0, IF_ID_flush=1, ID_EX_flush=1. load_cnt is cleared to 0 because the stalled ID instruction is squashed. mdu_cnt is unaffected, since the MDU op is already past EX.
  - ID_Jump with no stall: IF_ID_flush=1, PCWrite=1, ID_EX_flush=0.
  - ID_Jump with stall: flush is suppressed. The jump is re-presented after the stall releases.
- Simultaneous load_hit and mdu_stall: a single stall. Each counter evolves independently, and the stall lasts until both are clear.
- Counter widths: 4 bits (load), 6 bits (mdu). No wrap-around: decrement saturates at 0.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds output perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - Each increments by 1 per cycle with stall=1 (respectively IF_ID_flush=1).
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg holds:
  - REG_W=5 and the ZERO_REG constant
  - LD_IDLE/LD_WAIT state encodings
  - counter width constants LOAD_CNT_W=4, MDU_CNT_W=6
- One sub-module, stall_down_counter (load/decrement/saturate, busy flag). It is instantiated twice, for the load counter and the MDU counter.

Test Plan:
- Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8, LOAD_STALL_CYCLES=1 -> PCWrite=0, IF_ID_stall=1, ID_EX_flush=1 for exactly 1 cycle. With EX_Rt=0 -> no stall.
- Slow memory: LOAD_STALL_CYCLES=3, same hit -> stall for exactly 3 consecutive cycles, then PCWrite=1.
- MDU: EX_MduStart pulse, MDU_CYCLES=32, ID_HiLoRead=1 the next cycle -> stall for 31 cycles. mdu_busy falls in the same cycle the stall releases.
- Branch vs stall: LD_WAIT with load_cnt=2 and EX_BranchTaken=1 -> IF_ID_flush=1, ID_EX_flush=1, PCWrite=1. load_cnt=0 the next cycle, with no residual stall.
- Jump under stall: ID_Jump=1 together with load_hit -> IF_ID_flush=0 while stalled. IF_ID_flush=1 in the first cycle after release.
- Reset mid-operation: assert reset with mdu_cnt=20 -> outputs forced immediately. After release, mdu_busy=0 and no stall.
